// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch/decode slice: reset vector, NOP,
// fetch FSM state type and the opcode/funct encodings decode also uses.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8002_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Program counter for the fetch stage: sequential +4 advance, redirect
// override and word alignment of every loaded address.
module pc_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_reg
);

  logic [31:0] pc_d, pc_q;

  // Redirect wins over the sequential increment; the adder wraps mod 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = align_word(redirect_pc);
    else if (advance)    pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc_q <= align_word(RESET_PC);
    else          pc_q <= pc_d;
  end

  assign pc_reg = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack word reads from instruction memory,
// presenting insn/pc to decode. Build macro FETCH_DELAY_SLOT_EN keeps the
// word in flight at a redirect (branch delay slot) instead of squashing it.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        enable_decode,
  output logic        fetch_err,
  output logic        busy
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit SQUASH_EN = 1'b0;
`else
  localparam bit SQUASH_EN = 1'b1;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;
  logic             redir_d, redir_q;
  logic [31:0]      req_pc_d, req_pc_q;
  logic [31:0]      insn_d, insn_q;
  logic [31:0]      pc_d, pc_q;
  logic             en_d, en_q;
  logic             advance;
  logic [31:0]      pc_reg;

  logic         redir_seen, drop_ack, hold_drop, timed_out;
  fetch_state_e resume;

  // redir_q marks a request whose response comes back on the old path.
  assign redir_seen = redir_q || redirect_valid;
  assign drop_ack   = SQUASH_EN && redir_seen;
  assign hold_drop  = SQUASH_EN && redirect_valid;
  assign timed_out  = !mem_ack && (cnt_q == CNT_LAST);
  assign resume     = run ? ST_REQ : ST_IDLE;

  pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clock          (clock),
    .reset_n        (reset_n),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_reg         (pc_reg)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (run && !err_q) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack)        state_d = (drop_ack || !stall) ? resume : ST_HOLD;
        else if (timed_out) state_d = ST_IDLE;
      end
      ST_HOLD: if (hold_drop || !stall) state_d = resume;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    err_d    = err_q;
    redir_d  = redir_q;
    req_pc_d = req_pc_q;
    insn_d   = insn_q;
    pc_d     = pc_q;
    en_d     = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        cnt_d    = '0;
        redir_d  = redirect_valid;
        req_pc_d = pc_reg;
      end
      ST_WAIT: begin
        if (mem_ack) begin
          redir_d = 1'b0;
          if (!drop_ack) begin
            insn_d  = mem_rdata;
            pc_d    = req_pc_q;
            en_d    = 1'b1;
            advance = !redir_seen;
          end
        end else begin
          if (redirect_valid) redir_d = 1'b1;
          if (timed_out) err_d = 1'b1;
          else           cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: en_d = en_q && stall && !hold_drop;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      redir_q  <= 1'b0;
      req_pc_q <= '0;
      insn_q   <= NOP;
      pc_q     <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      redir_q  <= redir_d;
      req_pc_q <= req_pc_d;
      insn_q   <= insn_d;
      pc_q     <= pc_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    mem_req  = (state_q == ST_REQ);
    busy     = (state_q != ST_IDLE);
    mem_addr = pc_reg;
  end

  assign insn          = insn_q;
  assign pc            = pc_q;
  assign enable_decode = en_q;
  assign fetch_err     = err_q;

endmodule
